// File: rtl/imem_loader.sv
// RiSC16 instruction-memory loader: packs a host byte stream (high byte first)
// into words, writes them to consecutive addresses and keeps a running checksum.
module imem_loader #(
    parameter int WORD_LEN = 16,
    parameter int ADDR_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] base_addr,
    input  logic [ADDR_LEN-1:0] len,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                we,
    output logic [ADDR_LEN-1:0] waddr,
    output logic [WORD_LEN-1:0] wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic [WORD_LEN-1:0] checksum
);

    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

    state_t              state, state_nx;
    logic [7:0]          hi_byte, lo_byte;
    logic [ADDR_LEN-1:0] addr_cnt, len_r, word_cnt, word_inc;
    logic [WORD_LEN-1:0] csum;

    assign word_inc = word_cnt + 1'b1;
    assign checksum = csum;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        we       = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        waddr    = addr_cnt;
        wdata    = {hi_byte, lo_byte};
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (len == '0) ? DONE : HI;
            end
            HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = LO;
            end
            LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = WRITE;
            end
            WRITE: begin
                we       = 1'b1;
                state_nx = (word_inc == len_r) ? DONE : HI;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The core stays in reset for the whole load, including the done cycle.
    assign cpu_hold = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hi_byte  <= '0;
            lo_byte  <= '0;
            addr_cnt <= '0;
            len_r    <= '0;
            word_cnt <= '0;
            csum     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    addr_cnt <= base_addr;
                    len_r    <= len;
                    word_cnt <= '0;
                    csum     <= '0;
                end
                HI: if (in_valid) hi_byte <= in_data;
                LO: if (in_valid) lo_byte <= in_data;
                WRITE: begin
                    csum     <= csum + wdata;
                    addr_cnt <= addr_cnt + 1'b1;
                    word_cnt <= word_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: logs every write, checks addresses, data,
// checksum, done timing, stalls, wrap-around and mid-load reset.
module tb_imem_loader;

    logic        clk, rst, start, in_valid;
    logic [15:0] base_addr, len;
    logic [7:0]  in_data;
    logic        in_ready, we, cpu_hold, busy, done;
    logic [15:0] waddr, wdata, checksum;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .we(we),
        .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write log and event timestamps, sampled on the falling edge
    logic [15:0] wa[$];
    logic [15:0] wd[$];
    int   cyc = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0, hold_bad = 0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (we === 1'b1) begin
            wa.push_back(waddr);
            wd.push_back(wdata);
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy === 1'b1 && busy_q !== 1'b1) busy_cyc <= cyc;
        if (cpu_hold !== busy) hold_bad <= hold_bad + 1;
        busy_q <= busy;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        tick;
        start     = 1'b0;
    endtask

    // optional idle gap before the byte; junk=1 pulses start with bogus
    // base/len during the gap, which the loader must ignore
    task automatic send_byte(input logic [7:0] b, input int gap, input bit junk);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) begin
            if (junk) begin
                start     = 1'b1;
                base_addr = 16'hDEAD;
                len       = 16'h0007;
            end
            tick;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        ok       = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            tick;
        end
        chk("byte_accept", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        for (int i = 0; i < 20 && done_cnt == n0; i++) tick;
        chk("done_timeout", done_cnt - n0, 32'd1);
    endtask

    task automatic check_write(input int i, input logic [15:0] a, input logic [15:0] d);
        if (i < wa.size()) begin
            chk("waddr", wa[i], a);
            chk("wdata", wd[i], d);
        end else begin
            chk("write_missing", wa.size(), i + 1);
        end
    endtask

    int n0;

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        base_addr = 16'h0000; len = 16'h0005; in_data = 8'hAA;

        // reset dominates start and in_valid
        tick; tick;
        chk("rst_we",       we,       1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy",     busy,     1'b0);
        chk("rst_done",     done,     1'b0);
        chk("rst_hold",     cpu_hold, 1'b0);
        chk("rst_checksum", checksum, 16'h0000);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick;
        chk("idle_busy", busy, 1'b0);

        // basic back-to-back load: 3N cycles from first HI to the done cycle
        wa.delete(); wd.delete(); n0 = done_cnt;
        start_load(16'h0010, 16'd3);
        chk("hi_in_ready", in_ready, 1'b1);
        send_byte(8'h12, 0, 0); send_byte(8'h34, 0, 0);
        send_byte(8'hAB, 0, 0); send_byte(8'hCD, 0, 0);
        send_byte(8'h00, 0, 0); send_byte(8'hFF, 0, 0);
        wait_done(n0);
        chk("basic_nwrites", wa.size(), 3);
        check_write(0, 16'h0010, 16'h1234);
        check_write(1, 16'h0011, 16'hABCD);
        check_write(2, 16'h0012, 16'h00FF);
        chk("basic_done_lat", done_cyc - busy_cyc, 32'd9);
        chk("basic_checksum", checksum, 16'hBF00);
        tick; tick; tick;
        chk("hold_checksum", checksum, 16'hBF00);
        chk("after_busy",    busy,     1'b0);
        chk("after_done_cnt", done_cnt - n0, 1);

        // stalled stream with start pulses during the load
        wa.delete(); wd.delete(); n0 = done_cnt;
        start_load(16'h0010, 16'd3);
        send_byte(8'h12, 2, 1); send_byte(8'h34, 2, 1);
        send_byte(8'hAB, 2, 1); send_byte(8'hCD, 2, 1);
        send_byte(8'h00, 2, 1); send_byte(8'hFF, 2, 1);
        wait_done(n0);
        tick; tick;
        chk("stall_nwrites", wa.size(), 3);
        check_write(0, 16'h0010, 16'h1234);
        check_write(1, 16'h0011, 16'hABCD);
        check_write(2, 16'h0012, 16'h00FF);
        chk("stall_checksum", checksum, 16'hBF00);
        chk("stall_done_cnt", done_cnt - n0, 1);

        // zero-length load
        wa.delete(); wd.delete();
        start_load(16'h0040, 16'd0);
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b1);
        chk("len0_we",   we,   1'b0);
        tick;
        chk("len0_done_off", done, 1'b0);
        chk("len0_nwrites",  wa.size(), 0);
        chk("len0_checksum", checksum, 16'h0000);

        // address wrap
        wa.delete(); wd.delete(); n0 = done_cnt;
        start_load(16'hFFFF, 16'd2);
        send_byte(8'h00, 0, 0); send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0); send_byte(8'h02, 0, 0);
        wait_done(n0);
        chk("wrap_nwrites", wa.size(), 2);
        check_write(0, 16'hFFFF, 16'h0001);
        check_write(1, 16'h0000, 16'h0002);
        chk("wrap_checksum", checksum, 16'h0003);

        // reset in LO after one word written
        wa.delete(); wd.delete();
        start_load(16'h0020, 16'd3);
        send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
        send_byte(8'h33, 0, 0);
        chk("mid_in_lo", in_ready, 1'b1);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h44;
        tick;
        chk("mid_busy",     busy,     1'b0);
        chk("mid_in_ready", in_ready, 1'b0);
        chk("mid_we",       we,       1'b0);
        chk("mid_checksum", checksum, 16'h0000);
        rst = 1'b0; start = 1'b0;
        repeat (4) tick;
        in_valid = 1'b0;
        chk("mid_nwrites", wa.size(), 1);
        check_write(0, 16'h0020, 16'h1122);
        n0 = done_cnt;
        start_load(16'h0100, 16'd1);
        send_byte(8'h5A, 0, 0); send_byte(8'hA5, 0, 0);
        wait_done(n0);
        chk("reload_nwrites", wa.size(), 2);
        check_write(1, 16'h0100, 16'h5AA5);
        chk("reload_checksum", checksum, 16'h5AA5);

        tick;
        chk("cpu_hold_tracks_busy", hold_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
